pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter RADDR_WIDTH, default 5: register-address width, from the shared defines.
REQ-002 Parameter MEM_TIMEOUT, default 255: maximum memory-wait cycles before error.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 id_rs1_addr_i, id_rs2_addr_i  in  RADDR_WIDTH each  source registers of the instruction in ID.
REQ-006 id_rs1_re_i, id_rs2_re_i  in  1 each  source-read enables for ID.
REQ-007 exe_is_load_i, exe_reg_we_i  in  1 each  EXE instruction is a load; EXE writes a register.
REQ-008 exe_rd_addr_i  in  RADDR_WIDTH  EXE destination register.
REQ-009 exe_redirect_i  in  1  taken branch or jump resolved in EXE.
REQ-010 exe_mdu_start_i, mdu_done_i  in  1 each  multi-cycle mul/div launch; completion pulse.
REQ-011 mem_req_i, mem_ack_i  in  1 each  MEM-stage bus request; bus acknowledge.
REQ-012 stall_if_o, stall_id_o, stall_exe_o, stall_mem_o  out  1 each  hold PC, IF/ID, ID/EXE, EXE/MEM.
REQ-013 flush_id_o, flush_exe_o, flush_mem_o, flush_wb_o  out  1 each  insert NOP into IF/ID, ID/EXE, EXE/MEM, MEM/WB.
REQ-014 err_o  out  1  sticky memory-timeout error.
REQ-015 stall_cnt_o  out  32  count of cycles with stall_id_o high.

Function
REQ-016 The FSM SHALL have states RUN, MDU_WAIT, MEM_WAIT and ERR.
REQ-017 Condition mem_wait = mem_req_i & ~mem_ack_i.
REQ-018 Condition load_use = exe_is_load_i & exe_reg_we_i & exe_rd_addr_i != 0 & ((id_rs1_re_i & rs1 == rd) | (id_rs2_re_i & rs2 == rd)).
REQ-019 Priority, highest first: ERR, mem_wait, MDU wait, redirect, load_use.
REQ-020 mem_wait, in any non-ERR state: assert all four stalls and flush_wb_o, no other flush. State becomes MEM_WAIT on the next edge.
REQ-021 MEM_WAIT: leave on the first cycle mem_ack_i=1. Outputs are released combinationally in that cycle. Return to the state that was pre-empted (RUN or MDU_WAIT).
REQ-022 Wait counter: clear on entry to MEM_WAIT; increment each MEM_WAIT cycle. On reaching MEM_TIMEOUT, go to ERR and set err_o.
REQ-023 ERR: all four stalls asserted, all flushes low, err_o=1. Exit only by reset.
REQ-024 exe_mdu_start_i in RUN: assert stall_if/id/exe and flush_mem_o in the same cycle; go to MDU_WAIT.
REQ-025 MDU_WAIT with mdu_done_i=0: same outputs as REQ-024.
REQ-026 MDU_WAIT with mdu_done_i=1: all outputs low; go to RUN.
REQ-027 exe_redirect_i in RUN, no higher-priority condition: flush_id_o=flush_exe_o=1 for that cycle; load_use is suppressed.
REQ-028 exe_redirect_i SHALL be ignored while stall_exe_o is high.
REQ-029 load_use in RUN, no higher-priority condition: stall_if_o=stall_id_o=flush_exe_o=1 for exactly that cycle. No state change.
REQ-030 The same stage SHALL never have stall and flush asserted together. The pipeline registers give stall priority, so a combined assertion would lose the flush.
REQ-031 Register x0 SHALL never create a load-use hazard.
REQ-032 stall_cnt_o increments each cycle stall_id_o=1 and wraps from 0xFFFFFFFF to 0.
REQ-033 Latency: all stall/flush outputs are combinational from the current state and inputs. State, counters and err_o update on the rising edge.

Reset
REQ-034 While rst_ni=0: state=RUN, wait counter=0, stall_cnt_o=0, err_o=0, all stall/flush outputs 0.
REQ-035 Reset asserted mid-MDU_WAIT, MEM_WAIT or ERR SHALL abort to RUN immediately, with no pending-return memory kept.
REQ-036 Deassertion is asynchronous to clk_i; the first decision is taken on the first rising edge after deassertion.

Structure
REQ-037 State encodings and the MEM_TIMEOUT default belong in the shared defines file, alongside RADDR_WIDTH, ZERO_REG and NOP.
REQ-038 One sub-module, pipe_ctrl_hazard: combinational load_use and redirect decode. FSM and counters stay in pipe_ctrl.

Verification
REQ-039 lw x5 in EXE, add x6,x5,x1 in ID -> one cycle of stall_if/stall_id/flush_exe = 1,1,1; next cycle all 0; stall_cnt_o=1.
REQ-040 Load to x0 with rs1=0 in ID -> no stall or flush.
REQ-041 mdu_start, done after 4 cycles -> stall_exe_o high for 4 cycles, low in the done cycle, then state RUN.
REQ-042 mem_req with ack after 3 cycles, raised during MDU_WAIT -> all stalls plus flush_wb for 3 cycles, then return to MDU_WAIT.
REQ-043 mem_req never acked, MEM_TIMEOUT=8 -> err_o=1 after 8 wait cycles, all stalls stuck; rst_ni low clears everything.
REQ-044 Redirect and load_use in the same cycle -> flush_id=flush_exe=1, stall_id=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: register-file geometry, FSM encodings
// and the stall/flush bundle patterns driven by pipe_ctrl.
package pipe_ctrl_pkg;

  localparam int RADDR_WIDTH = 5;
  localparam int MEM_TIMEOUT = 255;
  localparam int ZERO_REG    = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_exe;
    logic stall_mem;
    logic flush_id;
    logic flush_exe;
    logic flush_mem;
    logic flush_wb;
  } ctrl_t;

  // Each pattern keeps stall and flush on different pipeline registers.
  localparam ctrl_t CTRL_NONE  = 8'b0000_0000;
  localparam ctrl_t CTRL_MEM   = 8'b1111_0001;
  localparam ctrl_t CTRL_MDU   = 8'b1110_0010;
  localparam ctrl_t CTRL_ERR   = 8'b1111_0000;
  localparam ctrl_t CTRL_REDIR = 8'b0000_1100;
  localparam ctrl_t CTRL_LU    = 8'b1100_0100;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational load-use and redirect decode; a redirect in the same cycle
// squashes the ID instruction, so it masks the load-use hazard.
module pipe_ctrl_hazard #(
  parameter int RADDR_WIDTH = pipe_ctrl_pkg::RADDR_WIDTH
) (
  input  logic [RADDR_WIDTH-1:0] rs1_addr,
  input  logic [RADDR_WIDTH-1:0] rs2_addr,
  input  logic                   rs1_re,
  input  logic                   rs2_re,
  input  logic                   exe_is_load,
  input  logic                   exe_reg_we,
  input  logic [RADDR_WIDTH-1:0] exe_rd_addr,
  input  logic                   exe_redirect,
  output logic                   load_use,
  output logic                   redirect
);
  import pipe_ctrl_pkg::*;

  logic rd_live;
  logic src_match;

  assign rd_live   = exe_is_load & exe_reg_we & (exe_rd_addr != RADDR_WIDTH'(ZERO_REG));
  assign src_match = (rs1_re & (rs1_addr == exe_rd_addr)) |
                     (rs2_re & (rs2_addr == exe_rd_addr));

  assign redirect = exe_redirect;
  assign load_use = rd_live & src_match & ~exe_redirect;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait, multi-cycle MDU, redirect and
// load-use handling; outputs are combinational, state updates on clk_i.
module pipe_ctrl #(
  parameter int RADDR_WIDTH = pipe_ctrl_pkg::RADDR_WIDTH,
  parameter int MEM_TIMEOUT = pipe_ctrl_pkg::MEM_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [RADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                   id_rs1_re_i,
  input  logic                   id_rs2_re_i,
  input  logic                   exe_is_load_i,
  input  logic                   exe_reg_we_i,
  input  logic [RADDR_WIDTH-1:0] exe_rd_addr_i,
  input  logic                   exe_redirect_i,
  input  logic                   exe_mdu_start_i,
  input  logic                   mdu_done_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ack_i,
  output logic                   stall_if_o,
  output logic                   stall_id_o,
  output logic                   stall_exe_o,
  output logic                   stall_mem_o,
  output logic                   flush_id_o,
  output logic                   flush_exe_o,
  output logic                   flush_mem_o,
  output logic                   flush_wb_o,
  output logic                   err_o,
  output logic [31:0]            stall_cnt_o
);
  import pipe_ctrl_pkg::*;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state, state_nxt, ret_state, ret_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          err_q, err_nxt;
  logic          mem_wait, load_use, redirect;
  ctrl_t         ctrl, ctrl_out;

  assign mem_wait = mem_req_i & ~mem_ack_i;

  pipe_ctrl_hazard #(.RADDR_WIDTH(RADDR_WIDTH)) u_hazard (
    .rs1_addr    (id_rs1_addr_i),
    .rs2_addr    (id_rs2_addr_i),
    .rs1_re      (id_rs1_re_i),
    .rs2_re      (id_rs2_re_i),
    .exe_is_load (exe_is_load_i),
    .exe_reg_we  (exe_reg_we_i),
    .exe_rd_addr (exe_rd_addr_i),
    .exe_redirect(exe_redirect_i),
    .load_use    (load_use),
    .redirect    (redirect)
  );

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    wait_nxt  = wait_cnt;
    err_nxt   = err_q;
    ctrl      = CTRL_NONE;
    case (state)
      ST_RUN, ST_MDU_WAIT: begin
        if (mem_wait) begin
          ctrl      = CTRL_MEM;
          state_nxt = ST_MEM_WAIT;
          ret_nxt   = state;
          wait_nxt  = '0;
        end else if (state == ST_MDU_WAIT) begin
          // Redirects are not acted on here: EXE is held while the MDU runs.
          if (!mdu_done_i) ctrl = CTRL_MDU;
          else             state_nxt = ST_RUN;
        end else if (exe_mdu_start_i) begin
          ctrl      = CTRL_MDU;
          state_nxt = ST_MDU_WAIT;
        end else if (redirect) begin
          ctrl = CTRL_REDIR;
        end else if (load_use) begin
          ctrl = CTRL_LU;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_nxt = ret_state;
        end else begin
          ctrl     = CTRL_MEM;
          wait_nxt = wait_cnt + 1'b1;
          if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
          end
        end
      end
      ST_ERR:  ctrl = CTRL_ERR;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign ctrl_out    = rst_ni ? ctrl : CTRL_NONE;
  assign stall_if_o  = ctrl_out.stall_if;
  assign stall_id_o  = ctrl_out.stall_id;
  assign stall_exe_o = ctrl_out.stall_exe;
  assign stall_mem_o = ctrl_out.stall_mem;
  assign flush_id_o  = ctrl_out.flush_id;
  assign flush_exe_o = ctrl_out.flush_exe;
  assign flush_mem_o = ctrl_out.flush_mem;
  assign flush_wb_o  = ctrl_out.flush_wb;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      wait_cnt    <= '0;
      err_q       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      wait_cnt  <= wait_nxt;
      err_q     <= err_nxt;
      if (ctrl_out.stall_id) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RUN-state hazard vector table plus hand
// sequences for MDU, memory wait, timeout and reset abort.
module tb_pipe_ctrl;

  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_MEM   = 8'b1111_0001;
  localparam logic [7:0] C_MDU   = 8'b1110_0010;
  localparam logic [7:0] C_ERR   = 8'b1111_0000;
  localparam logic [7:0] C_REDIR = 8'b0000_1100;
  localparam logic [7:0] C_LU    = 8'b1100_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic        re1, re2, ld, we, redir, mdu_start, mdu_done, mem_req, mem_ack;
  logic        s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, f_wb, err;
  logic [31:0] stall_cnt;
  logic [7:0]  outs;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  assign outs = {s_if, s_id, s_exe, s_mem, f_id, f_exe, f_mem, f_wb};

  pipe_ctrl #(.RADDR_WIDTH(5), .MEM_TIMEOUT(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .id_rs1_addr_i  (rs1),
    .id_rs2_addr_i  (rs2),
    .id_rs1_re_i    (re1),
    .id_rs2_re_i    (re2),
    .exe_is_load_i  (ld),
    .exe_reg_we_i   (we),
    .exe_rd_addr_i  (rd),
    .exe_redirect_i (redir),
    .exe_mdu_start_i(mdu_start),
    .mdu_done_i     (mdu_done),
    .mem_req_i      (mem_req),
    .mem_ack_i      (mem_ack),
    .stall_if_o     (s_if),
    .stall_id_o     (s_id),
    .stall_exe_o    (s_exe),
    .stall_mem_o    (s_mem),
    .flush_id_o     (f_id),
    .flush_exe_o    (f_exe),
    .flush_mem_o    (f_mem),
    .flush_wb_o     (f_wb),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       re1, re2, ld, we;
    logic [4:0] rd;
    logic       redir;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Inputs are already driven at a falling edge; check, then move to the next one.
  task automatic step(input string name, input logic [7:0] exp);
    #2;
    chk(name, {24'd0, outs}, {24'd0, exp});
    if (exp[6]) exp_cnt++;
    @(negedge clk);
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0;
    re1 = 0; re2 = 0; ld = 0; we = 0; redir = 0;
    mdu_start = 0; mdu_done = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_hz(input logic [4:0] a1, input logic [4:0] a2, input logic e1,
                        input logic e2, input logic l, input logic w,
                        input logic [4:0] d, input logic r);
    rs1 = a1; rs2 = a2; re1 = e1; re2 = e2; ld = l; we = w; rd = d; redir = r;
  endtask

  initial begin
    vecs[0] = '{5'd5,  5'd1,  1, 1, 1, 1, 5'd5,  0, C_LU,    "lw_rs1_hit"};
    vecs[1] = '{5'd0,  5'd0,  1, 0, 1, 1, 5'd0,  0, C_NONE,  "load_x0"};
    vecs[2] = '{5'd3,  5'd7,  1, 1, 1, 1, 5'd7,  0, C_LU,    "rs2_hit"};
    vecs[3] = '{5'd3,  5'd7,  1, 0, 1, 1, 5'd7,  0, C_NONE,  "rs2_not_read"};
    vecs[4] = '{5'd7,  5'd2,  1, 1, 1, 0, 5'd7,  0, C_NONE,  "load_no_we"};
    vecs[5] = '{5'd7,  5'd2,  1, 1, 0, 1, 5'd7,  0, C_NONE,  "alu_no_hazard"};
    vecs[6] = '{5'd9,  5'd4,  1, 1, 1, 1, 5'd9,  1, C_REDIR, "redir_and_lu"};
    vecs[7] = '{5'd1,  5'd2,  0, 0, 0, 0, 5'd0,  1, C_REDIR, "redir_only"};
    vecs[8] = '{5'd8,  5'd10, 1, 1, 1, 1, 5'd9,  0, C_NONE,  "no_match"};
    vecs[9] = '{5'd12, 5'd12, 0, 1, 1, 1, 5'd12, 0, C_LU,    "rs1_off_rs2_hit"};

    idle();
    @(negedge clk);
    set_hz(5'd5, 5'd1, 1, 1, 1, 1, 5'd5, 0);
    mem_req = 1;
    #1;
    chk("rst_outs", {24'd0, outs}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1;

    set_hz(5'd5, 5'd1, 1, 1, 1, 1, 5'd5, 0);
    step("lu_first", C_LU);
    idle();
    step("lu_release", C_NONE);
    chk("lu_cnt", stall_cnt, 32'd1);

    for (int i = 0; i < 10; i++) begin
      set_hz(vecs[i].rs1, vecs[i].rs2, vecs[i].re1, vecs[i].re2,
             vecs[i].ld, vecs[i].we, vecs[i].rd, vecs[i].redir);
      step(vecs[i].name, vecs[i].exp);
    end
    idle();
    chk("table_cnt", stall_cnt, exp_cnt);

    mdu_start = 1;
    step("mdu_start", C_MDU);
    mdu_start = 0;
    for (int i = 0; i < 3; i++) begin
      redir = (i == 1);
      step("mdu_wait", C_MDU);
    end
    redir = 0;
    mdu_done = 1;
    step("mdu_done", C_NONE);
    mdu_done = 0;
    redir = 1;
    step("mdu_back_run", C_REDIR);
    redir = 0;

    mem_req = 1;
    step("memrun_req", C_MEM);
    step("memrun_wait", C_MEM);
    mem_ack = 1;
    step("memrun_ack", C_NONE);
    idle();
    set_hz(5'd5, 5'd1, 1, 1, 1, 1, 5'd5, 0);
    step("memrun_back_run", C_LU);
    idle();

    mdu_start = 1;
    step("mdu_start2", C_MDU);
    mdu_start = 0;
    mem_req = 1;
    repeat (3) step("mem_in_mdu", C_MEM);
    mem_ack = 1;
    step("mem_ack_mdu", C_NONE);
    mem_req = 0; mem_ack = 0;
    step("mdu_resumed", C_MDU);
    mdu_done = 1;
    step("mdu_done2", C_NONE);
    mdu_done = 0;
    chk("mid_cnt", stall_cnt, exp_cnt);

    mem_req = 1;
    repeat (8) step("timeout_wait", C_MEM);
    chk("err_before_timeout", {31'd0, err}, 32'd0);
    step("timeout_last", C_MEM);
    chk("err_at_timeout", {31'd0, err}, 32'd1);
    mem_ack = 1; mdu_start = 1;
    step("err_stuck", C_ERR);
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_cnt", stall_cnt, exp_cnt);
    rst_n = 0;
    #1;
    exp_cnt = 0;
    chk("err_rst_outs", {24'd0, outs}, 32'd0);
    chk("err_rst_err", {31'd0, err}, 32'd0);
    chk("err_rst_cnt", stall_cnt, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1;
    set_hz(5'd5, 5'd1, 1, 1, 1, 1, 5'd5, 0);
    step("post_err_run", C_LU);
    idle();

    mdu_start = 1;
    step("abort_mdu_start", C_MDU);
    mdu_start = 0;
    rst_n = 0;
    #1;
    exp_cnt = 0;
    chk("abort_mdu_outs", {24'd0, outs}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step("abort_mdu_run", C_NONE);

    mem_req = 1;
    step("abort_mem_req", C_MEM);
    rst_n = 0;
    #1;
    exp_cnt = 0;
    mem_req = 0;
    @(negedge clk);
    rst_n = 1;
    step("abort_mem_run", C_NONE);
    chk("final_cnt", stall_cnt, exp_cnt);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
